// File: rtl/snes_bus_responder_pkg.sv
// Shared types and decode helpers for the SNES cartridge bus responder.
package snes_bus_responder_pkg;

    // Bus-cycle sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_HOLD = 3'd2,
        WR_CAPT = 3'd3,
        WR_REQ  = 3'd4
    } state_t;

    // Target selected by the address decoder
    typedef enum logic [1:0] {
        NONE = 2'd0,
        ROM  = 2'd1,
        RAM  = 2'd2,
        MMIO = 2'd3
    } region_t;

    // Offset windows inside the system banks (bank bit22 clear)
    localparam logic [15:0] MMIO_LO = 16'h3000;
    localparam logic [15:0] MMIO_HI = 16'h32FF;
    localparam logic [15:0] RAM_LO  = 16'h6000;
    localparam logic [15:0] RAM_HI  = 16'h7FFF;

    // Dedicated save-RAM banks 70-71 and F0-F1, compared on bank[7:1]
    localparam logic [6:0] SRAM_BANK_LO = 7'h38;
    localparam logic [6:0] SRAM_BANK_HI = 7'h78;

    // Classify a CPU address; MMIO beats RAM, RAM beats ROM.
    function automatic region_t decode_region(input logic [23:0] a);
        logic        sys_bank;
        logic        sram_bank;
        logic [15:0] off;
        region_t     rgn;
        sys_bank  = ~a[22];
        off       = a[15:0];
        sram_bank = (a[23:17] == SRAM_BANK_LO) || (a[23:17] == SRAM_BANK_HI);
        rgn       = NONE;
        if (sys_bank && (off >= MMIO_LO) && (off <= MMIO_HI))
            rgn = MMIO;
        else if ((sys_bank && (off >= RAM_LO) && (off <= RAM_HI)) || sram_bank)
            rgn = RAM;
        else if (!sys_bank || off[15])
            rgn = ROM;
        return rgn;
    endfunction

    // Physical ROM/RAM address; RAM addresses are 17 bits zero-extended.
    function automatic logic [20:0] form_mem_addr(input logic [23:0] a, input region_t rgn);
        logic [20:0] ma;
        if (rgn == RAM)
            ma = a[22] ? {4'd0, a[16:0]} : {4'd0, a[19:16], a[12:0]};
        else
            ma = a[22] ? a[20:0] : {a[21:16], a[14:0]};
        return ma;
    endfunction

    // The GSU can lock the CPU out of ROM or RAM; MMIO is always reachable.
    function automatic logic access_permitted(input region_t rgn, input logic own_rom,
                                              input logic own_ram);
        return (rgn != NONE) && !((rgn == ROM) && own_rom) && !((rgn == RAM) && own_ram);
    endfunction

endpackage

// File: rtl/snes_strobe_sync.sv
// Two-flop synchronizer for an active-low SNES strobe with edge pulses.
module snes_strobe_sync (
    input  logic clk,
    input  logic rst,
    input  logic strobe_n,
    output logic sync_n,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Idle-high synchronizer chain plus one delay stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= strobe_n;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_n = sync_q;
    assign rise   = sync_q & ~prev_q;
    assign fall   = ~sync_q & prev_q;

endmodule

// File: rtl/snes_bus_responder.sv
// Responds to SNES CPU bus cycles by forwarding them to cartridge ROM/RAM
// or to the MMIO register block, with GSU lockout, timeout and open bus.
module snes_bus_responder
    import snes_bus_responder_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 15,
    parameter logic [7:0]  OPEN_BUS       = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] snes_addr,
    input  logic        snes_rd_n,
    input  logic        snes_wr_n,
    input  logic [7:0]  snes_din,
    output logic [7:0]  snes_dout,
    output logic        snes_doe,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_is_ram,
    output logic [20:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        mmio_req,
    output logic        mmio_we,
    output logic [9:0]  mmio_addr,
    output logic [7:0]  mmio_wdata,
    input  logic        mmio_ack,
    input  logic [7:0]  mmio_rdata,
    input  logic        gsu_owns_rom,
    input  logic        gsu_owns_ram,
    output logic        timeout_err,
    output logic        proto_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [23:0]      lat_addr;
    logic [7:0]       lat_data;
    region_t          lat_rgn;
    logic [7:0]       wdata;

    logic rd_sync_n, rd_rise, rd_fall;
    logic wr_sync_n, wr_rise, wr_fall;

    snes_strobe_sync u_rd_sync (
        .clk      (clk),
        .rst      (rst),
        .strobe_n (snes_rd_n),
        .sync_n   (rd_sync_n),
        .rise     (rd_rise),
        .fall     (rd_fall)
    );

    snes_strobe_sync u_wr_sync (
        .clk      (clk),
        .rst      (rst),
        .strobe_n (snes_wr_n),
        .sync_n   (wr_sync_n),
        .rise     (wr_rise),
        .fall     (wr_fall)
    );

    // Reads decode the live bus; writes decode the address captured in WR_CAPT
    region_t cur_rgn;
    region_t wr_rgn;
    logic    cur_ok;
    logic    wr_ok;
    logic    req_busy;
    logic    ack_hit;
    logic    timed_out;
    logic [7:0] rdata_sel;

    assign cur_rgn   = decode_region(snes_addr);
    assign wr_rgn    = decode_region(lat_addr);
    assign cur_ok    = access_permitted(cur_rgn, gsu_owns_rom, gsu_owns_ram);
    assign wr_ok     = access_permitted(wr_rgn, gsu_owns_rom, gsu_owns_ram);
    assign req_busy  = mem_req | mmio_req;
    // Acks only count for the port that currently has a request out
    assign ack_hit   = (mem_req & mem_ack) | (mmio_req & mmio_ack);
    assign timed_out = req_busy & ~ack_hit & (cnt == CNT_LAST);
    assign rdata_sel = mmio_req ? mmio_rdata : mem_rdata;

    assign mem_wdata  = wdata;
    assign mmio_wdata = wdata;

    // Bus-cycle sequencer with registered request and bus outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_addr    <= '0;
            lat_data    <= '0;
            lat_rgn     <= NONE;
            wdata       <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_is_ram  <= 1'b0;
            mem_addr    <= '0;
            mmio_req    <= 1'b0;
            mmio_we     <= 1'b0;
            mmio_addr   <= '0;
            snes_dout   <= OPEN_BUS;
            snes_doe    <= 1'b0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rd_sync_n && !wr_sync_n) begin
                        // Both strobes low is illegal; flag it once, on the edge
                        if (rd_fall || wr_fall)
                            proto_err <= 1'b1;
                    end else if (rd_fall) begin
                        if (cur_ok) begin
                            lat_addr   <= snes_addr;
                            lat_rgn    <= cur_rgn;
                            mem_is_ram <= (cur_rgn == RAM);
                            mem_addr   <= form_mem_addr(snes_addr, cur_rgn);
                            mmio_addr  <= snes_addr[9:0];
                            cnt        <= '0;
                            state      <= RD_REQ;
                        end else begin
                            snes_dout <= OPEN_BUS;
                            snes_doe  <= 1'b1;
                            state     <= RD_HOLD;
                        end
                    end else if (wr_fall) begin
                        lat_addr <= snes_addr;
                        lat_data <= snes_din;
                        state    <= WR_CAPT;
                    end
                end

                RD_REQ, WR_REQ: begin
                    if (!req_busy) begin
                        // Issue on the first cycle in the state
                        if (lat_rgn == MMIO) begin
                            mmio_req <= 1'b1;
                            mmio_we  <= (state == WR_REQ);
                        end else begin
                            mem_req <= 1'b1;
                            mem_we  <= (state == WR_REQ);
                        end
                        cnt <= '0;
                    end else if (ack_hit || timed_out) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        mmio_req <= 1'b0;
                        mmio_we  <= 1'b0;
                        cnt      <= '0;
                        if (!ack_hit)
                            timeout_err <= 1'b1;
                        if (state == RD_REQ) begin
                            snes_dout <= ack_hit ? rdata_sel : OPEN_BUS;
                            snes_doe  <= 1'b1;
                            state     <= RD_HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RD_HOLD: begin
                    // The level check also frees the bus if the CPU let go of
                    // rd_n while the request was still outstanding
                    if (rd_rise || rd_sync_n) begin
                        snes_doe <= 1'b0;
                        state    <= IDLE;
                    end
                end

                WR_CAPT: begin
                    if (wr_rise) begin
                        // Use the values captured before the strobe went away
                        if (wr_ok) begin
                            lat_rgn    <= wr_rgn;
                            mem_is_ram <= (wr_rgn == RAM);
                            mem_addr   <= form_mem_addr(lat_addr, wr_rgn);
                            mmio_addr  <= lat_addr[9:0];
                            wdata      <= lat_data;
                            cnt        <= '0;
                            state      <= WR_REQ;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        lat_addr <= snes_addr;
                        lat_data <= snes_din;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snes_bus_responder.sv
// Self-checking bench for snes_bus_responder: directed scenarios plus a
// randomized sweep checked against an address-map reference model.
module tb_snes_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] snes_addr;
    logic        snes_rd_n, snes_wr_n;
    logic [7:0]  snes_din, snes_dout;
    logic        snes_doe;
    logic        mem_req, mem_we, mem_is_ram;
    logic [20:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        mmio_req, mmio_we;
    logic [9:0]  mmio_addr;
    logic [7:0]  mmio_wdata, mmio_rdata;
    logic        mmio_ack;
    logic        gsu_owns_rom, gsu_owns_ram;
    logic        timeout_err, proto_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Responder controls and observations
    int  ack_delay = 2;
    bit  ack_never = 0;
    bit  stray_ack = 0;
    int  wait_cnt = 0;
    bit  in_req = 0;
    int  req_cnt = 0, req_hi = 0, first_req_cyc = 0;
    int  overlap_cnt = 0, to_cnt = 0, pe_cnt = 0;
    bit  rec_mmio, rec_we, rec_ram;
    logic [20:0] rec_addr;
    logic [9:0]  rec_mmio_addr;
    logic [7:0]  rec_wdata;

    snes_bus_responder #(.TIMEOUT_CYCLES(15), .OPEN_BUS(8'hFF)) dut (
        .clk(clk), .rst(rst),
        .snes_addr(snes_addr), .snes_rd_n(snes_rd_n), .snes_wr_n(snes_wr_n),
        .snes_din(snes_din), .snes_dout(snes_dout), .snes_doe(snes_doe),
        .mem_req(mem_req), .mem_we(mem_we), .mem_is_ram(mem_is_ram),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .mmio_req(mmio_req), .mmio_we(mmio_we), .mmio_addr(mmio_addr),
        .mmio_wdata(mmio_wdata), .mmio_ack(mmio_ack), .mmio_rdata(mmio_rdata),
        .gsu_owns_rom(gsu_owns_rom), .gsu_owns_ram(gsu_owns_ram),
        .timeout_err(timeout_err), .proto_err(proto_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory/MMIO responder and protocol monitor, working on falling edges
    initial begin
        mem_ack = 1'b0;
        mmio_ack = 1'b0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            mmio_ack = 1'b0;
            if (mem_req && mmio_req) overlap_cnt++;
            if (timeout_err) to_cnt++;
            if (proto_err) pe_cnt++;
            if (mem_req || mmio_req) begin
                if (!in_req) begin
                    in_req = 1; wait_cnt = 0; req_hi = 0; req_cnt++;
                    first_req_cyc = cyc;
                    rec_mmio = mmio_req;
                    rec_we = mmio_req ? mmio_we : mem_we;
                    rec_ram = mem_is_ram;
                    rec_addr = mem_addr;
                    rec_mmio_addr = mmio_addr;
                    rec_wdata = mmio_req ? mmio_wdata : mem_wdata;
                end
                req_hi++;
                if (!ack_never && wait_cnt == ack_delay) begin
                    if (mmio_req) mmio_ack = 1'b1; else mem_ack = 1'b1;
                end
                wait_cnt++;
            end else begin
                in_req = 0;
                if (stray_ack) begin mem_ack = 1'b1; mmio_ack = 1'b1; end
            end
        end
    end

    // Reference address map: 0 none, 1 ROM, 2 RAM, 3 MMIO
    function automatic int model_region(input logic [23:0] a);
        int bank, off;
        bit sys;
        bank = int'(a[23:16]);
        off  = int'(a[15:0]);
        sys  = (bank < 'h40) || (bank >= 'h80 && bank < 'hC0);
        if (sys && off >= 'h3000 && off <= 'h32FF) return 3;
        if ((sys && off >= 'h6000 && off <= 'h7FFF) || bank == 'h70 || bank == 'h71 ||
            bank == 'hF0 || bank == 'hF1) return 2;
        if (!sys || off >= 'h8000) return 1;
        return 0;
    endfunction

    function automatic int model_addr(input logic [23:0] a, input int rgn);
        int bank, off, full;
        bit hi;
        bank = int'(a[23:16]);
        off  = int'(a[15:0]);
        full = int'(a);
        hi   = ((bank / 64) % 2) == 1;
        if (rgn == 2) return hi ? full % 131072 : (bank % 16) * 8192 + off % 8192;
        return hi ? full % 2097152 : (bank % 64) * 32768 + off % 32768;
    endfunction

    // Drive one CPU read; reports data, doe while held, doe just after release
    task automatic bus_read(input logic [23:0] a, output logic [7:0] d, output logic doe_hold,
                            output logic doe_mid, output logic doe_after, output int fc);
        int n;
        @(negedge clk);
        snes_addr = a;
        snes_rd_n = 1'b0;
        fc = cyc;
        n = 0;
        while (!snes_doe && n < 60) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        d = snes_dout;
        doe_hold = snes_doe;
        snes_rd_n = 1'b1;
        repeat (2) @(negedge clk);
        doe_mid = snes_doe;
        repeat (2) @(negedge clk);
        doe_after = snes_doe;
    endtask

    // Drive one CPU write; reports the cycle at which wr_n was released
    task automatic bus_write(input logic [23:0] a, input logic [7:0] d, output int rc);
        @(negedge clk);
        snes_addr = a;
        snes_din = d;
        snes_wr_n = 1'b0;
        repeat (4) @(negedge clk);
        snes_wr_n = 1'b1;
        rc = cyc;
        repeat (14) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if (mmio_req !== 1'b0) begin errors++; $display("FAIL reset_mmio_req got=%b exp=0", mmio_req); end
        checks++; if (mem_we !== 1'b0 || mmio_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b%b exp=00", mem_we, mmio_we); end
        checks++; if (snes_doe !== 1'b0) begin errors++; $display("FAIL reset_doe got=%b exp=0", snes_doe); end
        checks++; if (snes_dout !== 8'hFF) begin errors++; $display("FAIL reset_dout got=%h exp=ff", snes_dout); end
        checks++; if (timeout_err !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b%b exp=00", timeout_err, proto_err); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (req_cnt !== 0) begin errors++; $display("FAIL reset_no_req got=%0d exp=0", req_cnt); end
    endtask

    task automatic test_rom_read;
        logic [7:0] d; logic dh, dm, da; int fc, r0;
        ack_delay = 3; mem_rdata = 8'h5A; mmio_rdata = 8'h00;
        r0 = req_cnt;
        bus_read(24'h008123, d, dh, dm, da, fc);
        checks++; if (req_cnt !== r0 + 1) begin errors++; $display("FAIL rom_rd_count got=%0d exp=%0d", req_cnt - r0, 1); end
        checks++; if (rec_mmio !== 1'b0 || rec_we !== 1'b0 || rec_ram !== 1'b0) begin errors++; $display("FAIL rom_rd_kind got=mmio%b we%b ram%b exp=000", rec_mmio, rec_we, rec_ram); end
        checks++; if (rec_addr !== 21'h000123) begin errors++; $display("FAIL rom_rd_addr got=%h exp=000123", rec_addr); end
        checks++; if (first_req_cyc - fc !== 4) begin errors++; $display("FAIL rom_rd_latency got=%0d exp=4", first_req_cyc - fc); end
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL rom_rd_data got=%h exp=5a", d); end
        checks++; if (dh !== 1'b1 || dm !== 1'b1) begin errors++; $display("FAIL rom_rd_doe_hold got=%b%b exp=11", dh, dm); end
        checks++; if (da !== 1'b0) begin errors++; $display("FAIL rom_rd_doe_release got=%b exp=0", da); end
    endtask

    task automatic test_ram_write;
        int rc, r0;
        ack_delay = 1;
        r0 = req_cnt;
        bus_write(24'h701234, 8'hC3, rc);
        checks++; if (req_cnt !== r0 + 1) begin errors++; $display("FAIL ram_wr_count got=%0d exp=1", req_cnt - r0); end
        checks++; if (rec_mmio !== 1'b0 || rec_we !== 1'b1 || rec_ram !== 1'b1) begin errors++; $display("FAIL ram_wr_kind got=mmio%b we%b ram%b exp=011", rec_mmio, rec_we, rec_ram); end
        checks++; if (rec_addr !== 21'h001234) begin errors++; $display("FAIL ram_wr_addr got=%h exp=001234", rec_addr); end
        checks++; if (rec_wdata !== 8'hC3) begin errors++; $display("FAIL ram_wr_data got=%h exp=c3", rec_wdata); end
        checks++; if (first_req_cyc <= rc || first_req_cyc > rc + 5) begin errors++; $display("FAIL ram_wr_timing got=%0d exp=1..5 cycles after release", first_req_cyc - rc); end
    endtask

    task automatic test_mmio;
        logic [7:0] d; logic dh, dm, da; int fc, rc, r0, o0;
        ack_delay = 2; mmio_rdata = 8'h11; mem_rdata = 8'hEE;
        r0 = req_cnt; o0 = overlap_cnt;
        bus_read(24'h003030, d, dh, dm, da, fc);
        checks++; if (req_cnt !== r0 + 1 || rec_mmio !== 1'b1) begin errors++; $display("FAIL mmio_rd_kind got=cnt%0d mmio%b exp=cnt1 mmio1", req_cnt - r0, rec_mmio); end
        checks++; if (rec_mmio_addr !== 10'h030) begin errors++; $display("FAIL mmio_rd_addr got=%h exp=030", rec_mmio_addr); end
        checks++; if (d !== 8'h11) begin errors++; $display("FAIL mmio_rd_data got=%h exp=11", d); end
        bus_write(24'h003100, 8'h77, rc);
        checks++; if (rec_mmio !== 1'b1 || rec_we !== 1'b1 || rec_mmio_addr !== 10'h100) begin errors++; $display("FAIL mmio_wr got=mmio%b we%b addr%h exp=1 1 100", rec_mmio, rec_we, rec_mmio_addr); end
        checks++; if (rec_wdata !== 8'h77) begin errors++; $display("FAIL mmio_wr_data got=%h exp=77", rec_wdata); end
        checks++; if (overlap_cnt !== o0) begin errors++; $display("FAIL mmio_overlap got=%0d exp=0", overlap_cnt - o0); end
    endtask

    task automatic test_gsu_lock;
        logic [7:0] d; logic dh, dm, da; int fc, rc, r0;
        gsu_owns_rom = 1'b1; mem_rdata = 8'h42;
        r0 = req_cnt;
        bus_read(24'hC00000, d, dh, dm, da, fc);
        checks++; if (req_cnt !== r0) begin errors++; $display("FAIL gsu_rom_req got=%0d exp=0", req_cnt - r0); end
        checks++; if (d !== 8'hFF || dh !== 1'b1) begin errors++; $display("FAIL gsu_rom_open_bus got=%h doe%b exp=ff doe1", d, dh); end
        gsu_owns_rom = 1'b0; gsu_owns_ram = 1'b1;
        bus_write(24'h006000, 8'h99, rc);
        checks++; if (req_cnt !== r0) begin errors++; $display("FAIL gsu_ram_wr_req got=%0d exp=0", req_cnt - r0); end
        gsu_owns_ram = 1'b0;
    endtask

    task automatic test_timeout;
        logic [7:0] d; logic dh, dm, da; int fc, t0, r0;
        ack_never = 1; mem_rdata = 8'h33;
        t0 = to_cnt; r0 = req_cnt;
        bus_read(24'h400010, d, dh, dm, da, fc);
        checks++; if (to_cnt !== t0 + 1) begin errors++; $display("FAIL timeout_pulse got=%0d exp=1", to_cnt - t0); end
        checks++; if (req_hi !== 15) begin errors++; $display("FAIL timeout_req_cycles got=%0d exp=15", req_hi); end
        checks++; if (req_cnt !== r0 + 1 || rec_addr !== 21'h000010) begin errors++; $display("FAIL timeout_addr got=%h exp=000010", rec_addr); end
        checks++; if (d !== 8'hFF || dh !== 1'b1) begin errors++; $display("FAIL timeout_data got=%h doe%b exp=ff doe1", d, dh); end
        checks++; if (da !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL timeout_idle got=doe%b req%b exp=00", da, mem_req); end
        ack_never = 0;
    endtask

    task automatic test_proto_err;
        int p0, r0;
        p0 = pe_cnt; r0 = req_cnt;
        @(negedge clk);
        snes_addr = 24'h008000;
        snes_rd_n = 1'b0; snes_wr_n = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (pe_cnt !== p0 + 1) begin errors++; $display("FAIL proto_pulse got=%0d exp=1", pe_cnt - p0); end
        checks++; if (req_cnt !== r0 || snes_doe !== 1'b0) begin errors++; $display("FAIL proto_idle got=req%0d doe%b exp=0 0", req_cnt - r0, snes_doe); end
        snes_rd_n = 1'b1; snes_wr_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_stray_ack;
        logic [7:0] d; logic dh, dm, da; int fc, r0;
        stray_ack = 1;
        repeat (3) @(negedge clk);
        stray_ack = 0;
        ack_delay = 2; mem_rdata = 8'h3C; r0 = req_cnt;
        bus_read(24'h009000, d, dh, dm, da, fc);
        checks++; if (req_cnt !== r0 + 1 || rec_addr !== 21'h001000) begin errors++; $display("FAIL stray_ack_req got=cnt%0d addr%h exp=1 001000", req_cnt - r0, rec_addr); end
        checks++; if (d !== 8'h3C) begin errors++; $display("FAIL stray_ack_data got=%h exp=3c", d); end
    endtask

    task automatic test_reset_mid_read;
        logic [7:0] d; logic dh, dm, da; int fc, r0, n;
        ack_never = 1;
        @(negedge clk);
        snes_addr = 24'h008000;
        snes_rd_n = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin @(negedge clk); n++; end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req_seen got=%b exp=1", mem_req); end
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || snes_doe !== 1'b0) begin errors++; $display("FAIL rstmid_async got=req%b doe%b exp=00", mem_req, snes_doe); end
        snes_rd_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ack_never = 0;
        repeat (4) @(negedge clk);
        checks++; if (mem_req !== 1'b0 || mmio_req !== 1'b0) begin errors++; $display("FAIL rstmid_no_hold got=%b%b exp=00", mem_req, mmio_req); end
        ack_delay = 1; mem_rdata = 8'hA7; r0 = req_cnt;
        bus_read(24'h008001, d, dh, dm, da, fc);
        checks++; if (req_cnt !== r0 + 1 || d !== 8'hA7 || da !== 1'b0) begin errors++; $display("FAIL rstmid_next_read got=cnt%0d data%h doe%b exp=1 a7 0", req_cnt - r0, d, da); end
    endtask

    task automatic test_random;
        logic [23:0] a; logic [7:0] d, wd, exp_d; logic dh, dm, da;
        int fc, rc, r0, rgn, bank, off, ea;
        bit is_wr, lock, exp_req;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: off = $urandom_range('h3000, 'h32FF);
                1: off = $urandom_range('h6000, 'h7FFF);
                2: off = $urandom_range('h8000, 'hFFFF);
                default: off = $urandom_range(0, 'hFFFF);
            endcase
            if ($urandom_range(0, 4) == 0) bank = ($urandom_range(0, 1) ? 'hF0 : 'h70) + $urandom_range(0, 1);
            else bank = $urandom_range(0, 255);
            a = 24'(bank * 65536 + off);
            gsu_owns_rom = ($urandom_range(0, 3) == 0);
            gsu_owns_ram = ($urandom_range(0, 3) == 0);
            ack_delay = $urandom_range(0, 4);
            mem_rdata = 8'($urandom); mmio_rdata = 8'($urandom); wd = 8'($urandom);
            is_wr = $urandom_range(0, 1);
            rgn = model_region(a);
            lock = (rgn == 1 && gsu_owns_rom) || (rgn == 2 && gsu_owns_ram);
            exp_req = (rgn != 0) && !lock;
            r0 = req_cnt;
            if (is_wr) bus_write(a, wd, rc);
            else bus_read(a, d, dh, dm, da, fc);
            checks++; if (req_cnt !== r0 + int'(exp_req)) begin errors++; $display("FAIL rnd_req_count addr=%h got=%0d exp=%0d", a, req_cnt - r0, exp_req); end
            if (exp_req) begin
                checks++; if (rec_mmio !== (rgn == 3) || rec_we !== is_wr) begin errors++; $display("FAIL rnd_kind addr=%h got=mmio%b we%b exp=mmio%b we%b", a, rec_mmio, rec_we, rgn == 3, is_wr); end
                if (rgn == 3) begin
                    checks++; if (rec_mmio_addr !== a[9:0]) begin errors++; $display("FAIL rnd_mmio_addr addr=%h got=%h exp=%h", a, rec_mmio_addr, a[9:0]); end
                end else begin
                    ea = model_addr(a, rgn);
                    checks++; if (rec_addr !== 21'(ea) || rec_ram !== (rgn == 2)) begin errors++; $display("FAIL rnd_mem_addr addr=%h got=%h ram%b exp=%h ram%b", a, rec_addr, rec_ram, 21'(ea), rgn == 2); end
                end
                if (is_wr) begin
                    checks++; if (rec_wdata !== wd) begin errors++; $display("FAIL rnd_wdata addr=%h got=%h exp=%h", a, rec_wdata, wd); end
                end
            end
            if (!is_wr) begin
                exp_d = !exp_req ? 8'hFF : (rgn == 3 ? mmio_rdata : mem_rdata);
                checks++; if (d !== exp_d || dh !== 1'b1 || da !== 1'b0) begin errors++; $display("FAIL rnd_read addr=%h got=%h doe%b%b exp=%h doe10", a, d, dh, da, exp_d); end
            end
        end
        gsu_owns_rom = 1'b0; gsu_owns_ram = 1'b0;
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL rnd_overlap got=%0d exp=0", overlap_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        snes_addr = '0; snes_rd_n = 1'b1; snes_wr_n = 1'b1; snes_din = '0;
        gsu_owns_rom = 1'b0; gsu_owns_ram = 1'b0;
        mem_rdata = '0; mmio_rdata = '0;
        test_reset;
        test_rom_read;
        test_ram_write;
        test_mmio;
        test_gsu_lock;
        test_timeout;
        test_proto_err;
        test_stray_ack;
        test_reset_mid_read;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snes_bus_responder.md
SNES_BUS_RESPONDER -- requirements
Module: snes_bus_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15: maximum cycles to wait for an ack before aborting.
REQ-002 SHALL have parameter OPEN_BUS, default 8'hFF: read data for unmapped, aborted or locked-out accesses.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge system clock; rst input 1, asynchronous active-high reset.
REQ-004 SHALL have SNES bus ports: snes_addr input 24, CPU address; snes_rd_n input 1, async read strobe; snes_wr_n input 1, async write strobe; snes_din input 8, CPU write data; snes_dout output 8, read data; snes_doe output 1, data-bus drive enable.
REQ-005 SHALL have memory ports: mem_req output 1, request; mem_we output 1, write; mem_is_ram output 1 (0=ROM, 1=RAM); mem_addr output 21, ROM byte addr or RAM addr zero-extended from 17; mem_wdata output 8; mem_ack input 1, one-cycle completion; mem_rdata input 8, valid with ack.
REQ-006 SHALL have MMIO ports: mmio_req output 1; mmio_we output 1; mmio_addr output 10; mmio_wdata output 8; mmio_ack input 1; mmio_rdata input 8.
REQ-007 SHALL have ownership/status ports: gsu_owns_rom input 1; gsu_owns_ram input 1; timeout_err output 1, one-cycle pulse; proto_err output 1, one-cycle pulse.

Function
REQ-008 SHALL synchronize snes_rd_n/snes_wr_n through two flops and detect edges on the synchronized value.
REQ-009 SHALL decode: ROM = bank bit22 set, or offset bit15 set in banks 00-3F/80-BF; RAM = offset 6000-7FFF in banks 00-3F/80-BF, or banks 70-71/F0-F1; MMIO = offset 3000-32FF in banks 00-3F/80-BF. MMIO decode SHALL take priority over RAM, and RAM over ROM.
REQ-010 SHALL form addresses as follows. ROM, banks with bit22 clear: {addr[21:16],addr[14:0]}. ROM, bit22 set: addr[20:0]. RAM, bit22 clear: {addr[19:16],addr[12:0]}. RAM, bit22 set: addr[16:0]. MMIO: addr[9:0].
REQ-011 SHALL implement FSM states IDLE, RD_REQ, RD_HOLD, WR_CAPT, WR_REQ.
REQ-012 IDLE SHALL move on a synchronized rd_n falling edge. Target ROM/RAM/MMIO and permitted: latch address, go to RD_REQ. Otherwise: load OPEN_BUS into snes_dout, go to RD_HOLD.
REQ-013 ROM access while gsu_owns_rom=1, or RAM access while gsu_owns_ram=1, SHALL NOT issue a request and SHALL return OPEN_BUS.
REQ-014 RD_REQ SHALL hold the request until ack. On the ack cycle it SHALL capture rdata into snes_dout, drop req on the next cycle, and enter RD_HOLD.
REQ-015 RD_HOLD SHALL assert snes_doe and return to IDLE on the synchronized rd_n rising edge. snes_doe SHALL deassert in that same cycle.
REQ-016 A synchronized wr_n falling edge SHALL enter WR_CAPT, which registers snes_addr and snes_din every cycle.
REQ-017 On the wr_n rising edge, WR_CAPT SHALL go to WR_REQ using the values registered on the previous cycle. A write to an unmapped or locked target SHALL be dropped and return to IDLE.
REQ-018 WR_REQ SHALL hold req/we/wdata until ack, then return to IDLE.
REQ-019 Requests SHALL be issued first-cycle-after-state-entry: mem_req rises 4 clk after the raw rd_n falling edge.
REQ-020 A cycle counter SHALL run in RD_REQ/WR_REQ. If ack is absent for TIMEOUT_CYCLES cycles, the block SHALL deassert req, pulse timeout_err, load OPEN_BUS (reads), and advance as if acked.
REQ-021 Synchronized rd_n and wr_n both low in IDLE SHALL pulse proto_err and remain in IDLE. A strobe edge outside IDLE SHALL be ignored.
REQ-022 mem_req and mmio_req SHALL never be high together, and at most one request SHALL be in flight.
REQ-023 An ack arriving while req is low SHALL be ignored.

Reset
REQ-024 rst SHALL force IDLE and zero the counter. It SHALL clear mem_req, mmio_req, *_we, snes_doe, timeout_err and proto_err. snes_dout SHALL reset to OPEN_BUS. Synchronizer flops SHALL reset to 1.
REQ-025 Reset during RD_REQ/WR_REQ SHALL abandon the access, with no request held after rst deasserts.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the region-select enum (NONE/ROM/RAM/MMIO) and the decode address constants.
REQ-027 SHALL instantiate one sub-module, snes_strobe_sync: a two-flop synchronizer plus rise/fall edge pulses, used once per strobe.

Verification
REQ-028 Read 00:8123, ack after 3 cycles with rdata=8'h5A -> mem_req high, mem_is_ram=0, mem_addr=21'h000123; snes_dout=8'h5A with doe high until rd_n rises.
REQ-029 Write 8'hC3 to 70:1234 -> mem_we=1, mem_is_ram=1, mem_addr=21'h01234, mem_wdata=8'hC3, issued after wr_n rises.
REQ-030 Read 00:3030 with mmio_rdata=8'h11 -> mmio_addr=10'h030, mem_req stays low, snes_dout=8'h11.
REQ-031 gsu_owns_rom=1, read C0:0000 -> no mem_req; snes_dout=8'hFF.
REQ-032 Read 40:0010 with ack never given -> timeout_err pulses once after 15 req cycles; snes_dout=8'hFF; FSM returns to IDLE after rd_n rises.
REQ-033 rst asserted mid RD_REQ -> mem_req low asynchronously; snes_doe=0; next read completes normally.
